ex_hilo_muldiv: RTL and testbench

- Execute-stage iterative multiply/divide unit that owns the architectural HI/LO registers.
- Consumes operands and the HI/LO control decoded by ID and registered in the ID/EX pipeline buffer (ReadData1/ReadData2, hilo op).
- Runs multi-cycle MULT/MULTU/DIV/DIVU, plus single-cycle MTHI/MTLO.
- Drives a stall back to the hazard logic while busy, so that later HI/LO accesses wait.

---
 rtl/ex_hilo_muldiv.sv | 180 ++++++++++++++++++
 tb/tb_ex_hilo_muldiv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_hilo_muldiv
// Brief    : Iterative radix-2 multiply/divide unit that owns HI/LO.
//            Build option HILO_MADD_EN adds MADD/MSUB accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module ex_hilo_muldiv #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             start_in,
   input  logic [2:0]       op_in,
   input  logic [WIDTH-1:0] ReadData1_in,
   input  logic [WIDTH-1:0] ReadData2_in,
   input  logic             hilo_read_in,
   input  logic             flush,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             Stall_out
);

   localparam int              c_CW   = $clog2(ITER + 1);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [WIDTH-1:0] r_hi, r_lo;
   logic [WIDTH-1:0] r_opnd;              // multiplicand or divisor magnitude
   logic [WIDTH-1:0] r_p_hi, r_p_lo;      // product, or remainder:quotient
   logic [WIDTH-1:0] r_res_hi, r_res_lo;
   logic [WIDTH-1:0] r_a_raw;
   logic [c_CW-1:0]  r_cnt;
   logic             r_is_div, r_neg_q, r_neg_r, r_dz;
`ifdef HILO_MADD_EN
   logic             r_acc_en, r_acc_sub;
`endif

   logic                 w_idle, w_is_madd, w_mul_op, w_div_op, w_signed;
   logic                 w_go, w_mt, w_a_neg, w_b_neg, w_qbit;
   logic [WIDTH-1:0]     w_a_abs, w_b_abs, w_sub;
   logic [WIDTH:0]       w_mul_sum, w_rem_sh;
   logic [2*WIDTH-1:0]   w_prod, w_prod_fix, w_res, w_hilo_new;

   // ---------------- decode ----------------
`ifdef HILO_MADD_EN
   assign w_is_madd = op_in[2] & op_in[1];
`else
   assign w_is_madd = 1'b0;
`endif
   assign w_idle   = (r_state == S_IDLE);
   assign w_mul_op = (op_in[2:1] == 2'b00) | w_is_madd;
   assign w_div_op = (op_in[2:1] == 2'b01);
   assign w_signed = ~op_in[0] | w_is_madd;
   assign w_go     = w_idle & start_in & ~flush & (w_mul_op | w_div_op);
   assign w_mt     = w_idle & start_in & ~flush & (op_in[2:1] == 2'b10);

   assign w_a_neg  = w_signed & ReadData1_in[WIDTH-1];
   assign w_b_neg  = w_signed & ReadData2_in[WIDTH-1];
   assign w_a_abs  = w_a_neg ? -ReadData1_in : ReadData1_in;
   assign w_b_abs  = w_b_neg ? -ReadData2_in : ReadData2_in;

   // ---------------- iteration datapath ----------------
   assign w_mul_sum  = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_rem_sh   = {r_p_hi, r_p_lo[WIDTH-1]};
   assign w_qbit     = (w_rem_sh >= {1'b0, r_opnd});
   // Only consumed when the trial succeeds, so the true difference fits WIDTH bits
   assign w_sub      = w_rem_sh[WIDTH-1:0] - r_opnd;
   assign w_prod     = {r_p_hi, r_p_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_res      = {r_res_hi, r_res_lo};

`ifdef HILO_MADD_EN
   assign w_hilo_new = !r_acc_en ? w_res :
                       r_acc_sub ? ({r_hi, r_lo} - w_res) : ({r_hi, r_lo} + w_res);
`else
   assign w_hilo_new = w_res;
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_state_nxt = S_RUN;
         S_RUN:   if (flush) w_state_nxt = S_IDLE;
                  else if (r_cnt == c_LAST) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_hi     <= '0;  r_lo     <= '0;
         r_opnd   <= '0;  r_a_raw  <= '0;
         r_p_hi   <= '0;  r_p_lo   <= '0;
         r_res_hi <= '0;  r_res_lo <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_dz <= 1'b0;
`ifdef HILO_MADD_EN
         r_acc_en <= 1'b0; r_acc_sub <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_is_div <= w_div_op;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_dz     <= w_div_op & (ReadData2_in == '0);
                  r_a_raw  <= ReadData1_in;
                  r_opnd   <= w_div_op ? w_b_abs : w_a_abs;
                  r_p_lo   <= w_div_op ? w_a_abs : w_b_abs;
                  r_p_hi   <= '0;
                  r_cnt    <= '0;
`ifdef HILO_MADD_EN
                  r_acc_en  <= w_is_madd;
                  r_acc_sub <= op_in[0];
`endif
               end else if (w_mt) begin
                  if (op_in[0]) r_lo <= ReadData1_in;
                  else          r_hi <= ReadData1_in;
               end
            end
            S_RUN: begin
               if (!flush) begin
                  if (r_cnt != c_LAST) begin
                     r_cnt <= r_cnt + c_CW'(1);
                     if (r_is_div) begin
                        r_p_hi <= w_qbit ? w_sub : w_rem_sh[WIDTH-1:0];
                        r_p_lo <= {r_p_lo[WIDTH-2:0], w_qbit};
                     end else begin
                        r_p_hi <= w_mul_sum[WIDTH:1];
                        r_p_lo <= {w_mul_sum[0], r_p_lo[WIDTH-1:1]};
                     end
                  end else if (r_is_div) begin
                     // Final RUN cycle registers the sign-corrected result
                     if (r_dz) begin
                        r_res_hi <= r_a_raw;
                        r_res_lo <= '1;
                     end else begin
                        r_res_hi <= r_neg_r ? -r_p_hi : r_p_hi;
                        r_res_lo <= r_neg_q ? -r_p_lo : r_p_lo;
                     end
                  end else begin
                     {r_res_hi, r_res_lo} <= w_prod_fix;
                  end
               end
            end
            S_FIX: begin
               if (!flush) {r_hi, r_lo} <= w_hilo_new;
            end
            default: ;
         endcase
      end
   end

   assign hi_out    = r_hi;
   assign lo_out    = r_lo;
   assign busy_out  = ~w_idle;
   assign done_out  = (r_state == S_FIX) & ~flush;
   assign Stall_out = busy_out & (start_in | hilo_read_in);

endmodule
`default_nettype wire

// File: tb/tb_ex_hilo_muldiv.sv
`default_nettype none
// Bench for ex_hilo_muldiv: directed literal cases followed by random traffic
// compared every cycle against an arithmetic model of HI/LO behaviour.
module tb_ex_hilo_muldiv;

   localparam int LAT = 34;

   logic        Clk;
   logic        Rst_n, start_in, hilo_read_in, flush;
   logic [2:0]  op_in;
   logic [31:0] rd1, rd2;
   logic [31:0] hi_out, lo_out;
   logic        busy_out, done_out, Stall_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_hi, m_lo;
   logic [63:0] m_res;
   logic [2:0]  m_op;
   int          m_cnt;

   ex_hilo_muldiv #(.WIDTH(32), .ITER(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .start_in(start_in), .op_in(op_in),
      .ReadData1_in(rd1), .ReadData2_in(rd2), .hilo_read_in(hilo_read_in),
      .flush(flush), .hi_out(hi_out), .lo_out(lo_out), .busy_out(busy_out),
      .done_out(done_out), .Stall_out(Stall_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Full {HI,LO} result of a multi-cycle op from plain arithmetic
   function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
         default: return sa * sb;
      endcase
   endfunction

   // Model advance for the posedge just passed, then compare every output
   initial begin
      m_hi = 0; m_lo = 0; m_cnt = 0; m_res = 0; m_op = 0;
      forever begin
         @(negedge Clk);
         if (!Rst_n) begin
            m_hi = 0; m_lo = 0; m_cnt = 0;
         end else if (m_cnt != 0) begin
            if (flush) m_cnt = 0;
            else if (m_cnt == LAT) begin
               case (m_op)
                  3'd6:    {m_hi, m_lo} = {m_hi, m_lo} + m_res;
                  3'd7:    {m_hi, m_lo} = {m_hi, m_lo} - m_res;
                  default: {m_hi, m_lo} = m_res;
               endcase
               m_cnt = 0;
            end else m_cnt++;
         end else if (start_in && !flush) begin
            case (op_in)
               3'd0, 3'd1, 3'd2, 3'd3: begin
                  m_op = op_in; m_res = model_res(op_in, rd1, rd2); m_cnt = 1;
               end
               3'd4: m_hi = rd1;
               3'd5: m_lo = rd1;
               default: begin
`ifdef HILO_MADD_EN
                  m_op = op_in; m_res = model_res(3'd0, rd1, rd2); m_cnt = 1;
`endif
               end
            endcase
         end
         chk("hi", hi_out, m_hi);
         chk("lo", lo_out, m_lo);
         chk("busy", busy_out, m_cnt != 0);
         chk("done", done_out, (m_cnt == LAT) && !flush);
         chk("stall", Stall_out, (m_cnt != 0) && (start_in || hilo_read_in));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic mt(input logic [2:0] op, input logic [31:0] v);
      @(negedge Clk); #1;
      start_in = 1; op_in = op; rd1 = v; rd2 = 0;
      @(negedge Clk); #1;
      start_in = 0;
   endtask

   // Issue one op from IDLE and wait for it; lat counts busy cycles
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int dones);
      @(negedge Clk); #1;
      start_in = 1; op_in = op; rd1 = a; rd2 = b;
      @(negedge Clk); #1;
      start_in = 0;
      lat = 0; dones = 0;
      while (busy_out && lat < 200) begin
         lat++;
         if (done_out) dones++;
         @(negedge Clk); #1;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int lat, dones, k;
      Rst_n = 0; start_in = 0; op_in = 0; rd1 = 0; rd2 = 0; hilo_read_in = 0; flush = 0;
      repeat (2) @(negedge Clk);
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      #1 Rst_n = 1;

      // reset in the middle of an op
      mt(3'd4, 32'h77);
      @(negedge Clk); #1;
      start_in = 1; op_in = 3'd1; rd1 = 2; rd2 = 3;
      @(negedge Clk); #1;
      start_in = 0;
      repeat (10) @(negedge Clk);
      #1 Rst_n = 0;
      #1;
      chk("midrst_hi", hi_out, 0);
      chk("midrst_busy", busy_out, 0);
      @(negedge Clk); #1 Rst_n = 1;
      run_op(3'd1, 32'd2, 32'd3, lat, dones);
      chk("multu_lo", lo_out, 32'd6);
      chk("multu_hi", hi_out, 32'd0);

      run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, dones);
      chk("mult_hi", hi_out, 32'hFFFF_FFFF);
      chk("mult_lo", lo_out, 32'hFFFF_FFF1);
      chk("mult_latency", lat, LAT);
      chk("mult_dones", dones, 1);

      run_op(3'd3, 32'd100, 32'd7, lat, dones);
      chk("divu_lo", lo_out, 32'h0000_000E);
      chk("divu_hi", hi_out, 32'h0000_0002);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, dones);
      chk("div_lo", lo_out, 32'hFFFF_FFFD);
      chk("div_hi", hi_out, 32'hFFFF_FFFF);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, dones);
      chk("divovf_lo", lo_out, 32'h8000_0000);
      chk("divovf_hi", hi_out, 32'h0);

      // divide by zero, with MTLO held by the stall until IDLE
      @(negedge Clk); #1;
      start_in = 1; op_in = 3'd3; rd1 = 32'h1234; rd2 = 0;
      @(negedge Clk); #1;
      op_in = 3'd5; rd1 = 32'hAA; rd2 = 0;
      k = 0;
      while (Stall_out && k < 200) begin
         k++;
         @(negedge Clk);
      end
      chk("stall_cycles", k, LAT);
      chk("dz_lo", lo_out, 32'hFFFF_FFFF);
      chk("dz_hi", hi_out, 32'h0000_1234);
      @(negedge Clk); #1;
      start_in = 0;
      chk("mtlo_after_stall", lo_out, 32'hAA);

      // flush mid-op keeps HI/LO
      mt(3'd4, 32'h5);
      mt(3'd5, 32'h6);
      @(negedge Clk); #1;
      start_in = 1; op_in = 3'd0; rd1 = 9; rd2 = 9;
      @(negedge Clk); #1;
      start_in = 0;
      dones = 0;
      repeat (9) begin
         @(negedge Clk);
         if (done_out) dones++;
      end
      #1 flush = 1;
      @(negedge Clk); #1;
      flush = 0;
      chk("flush_busy", busy_out, 0);
      chk("flush_hi", hi_out, 32'h5);
      chk("flush_lo", lo_out, 32'h6);
      chk("flush_dones", dones, 0);

`ifdef HILO_MADD_EN
      mt(3'd4, 32'h0);
      mt(3'd5, 32'd10);
      run_op(3'd6, 32'd3, 32'd4, lat, dones);
      chk("madd_lo", lo_out, 32'd22);
      chk("madd_hi", hi_out, 32'd0);
      run_op(3'd7, 32'd5, 32'd5, lat, dones);
      chk("msub_hi", hi_out, 32'hFFFF_FFFF);
      chk("msub_lo", lo_out, 32'hFFFF_FFFD);
`else
      @(negedge Clk); #1;
      start_in = 1; op_in = 3'd6; rd1 = 32'd3; rd2 = 32'd4;
      @(negedge Clk); #1;
      start_in = 0;
      chk("op6_busy", busy_out, 0);
      chk("op6_hi", hi_out, 32'h5);
      chk("op6_lo", lo_out, 32'h6);
`endif

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge Clk); #1;
         start_in     = ($urandom_range(0, 3) == 0);
         op_in        = 3'($urandom_range(0, 7));
         rd1          = pick();
         rd2          = pick();
         hilo_read_in = $urandom_range(0, 1) == 1;
         flush        = ($urandom_range(0, 99) == 0);
         Rst_n        = ($urandom_range(0, 799) != 0);
      end
      @(negedge Clk); #1;
      start_in = 0; flush = 0; hilo_read_in = 0; Rst_n = 1;
      repeat (40) @(negedge Clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
